ahb_sram_subordinate: RTL and testbench



---
 rtl/ahb_sram_subordinate_pkg.sv | 34 +++
 rtl/ahb_sram_subordinate_array.sv | 29 ++
 rtl/ahb_sram_subordinate.sv | 164 ++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_subordinate_pkg.sv
// Shared AHB encodings, subordinate FSM states and the byte-lane mask helper
// for the SRAM-backed AHB subordinate.
package ahb_sram_subordinate_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } sram_state_e;

  // Byte lanes touched by a transfer of 2**size bytes starting at lane offset.
  function automatic logic [7:0] size_to_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] span;
    case (size)
      3'd0:    span = 8'h01;
      3'd1:    span = 8'h03;
      3'd2:    span = 8'h0F;
      default: span = 8'hFF;
    endcase
    return span << offset;
  endfunction

endpackage

// File: rtl/ahb_sram_subordinate_array.sv
// Word-organised storage with byte-enable writes and a registered read port.
// Storage and read register are deliberately not reset so contents survive HRESET.
module ahb_sram_subordinate_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-first on a same-word collision; the top forwards the merged word instead.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate backed by a byte-enable SRAM: programmable wait states,
// two-cycle ERROR for out-of-range, oversize or misaligned accesses.
module ahb_sram_subordinate
  import ahb_sram_subordinate_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HEXOKAY
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(STRB_W);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

  sram_state_e           state_q;
  logic [2:0]            cnt_q;
  logic                  hreadyout_q, hresp_q;
  logic                  dp_valid_q, write_q, err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [2:0]            off_q, size_q;
  logic                  fwd_valid_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  logic                  trans_active, accept, req_err, commit, read_done;
  logic                  range_err, size_err, misalign;
  logic [2:0]            align_mask;
  logic [IDX_W-1:0]      rd_idx;
  logic [7:0]            lane_mask;
  logic [STRB_W-1:0]     wr_strb;
  logic [DATA_WIDTH-1:0] bit_mask, arr_rdata, word_view, merged;
  logic                  unused_hburst;

  assign unused_hburst = ^HBURST;

  assign trans_active = (htrans_e'(HTRANS) == TransNonseq) || (htrans_e'(HTRANS) == TransSeq);
  assign accept       = HSEL & HREADY & trans_active & hreadyout_q;

  assign range_err  = (HADDR >> LANE_BITS) >= ADDR_WIDTH'(MEM_DEPTH);
  assign size_err   = HSIZE > 3'(LANE_BITS);
  assign align_mask = 3'((4'd1 << HSIZE) - 4'd1);
  assign misalign   = |(HADDR[2:0] & align_mask);
  assign req_err    = range_err | size_err | misalign;
  assign rd_idx     = HADDR[LANE_BITS +: IDX_W];

  // Only a completing OKAY data phase commits; ERR2 also has ready high but err_q blocks it.
  assign commit    = dp_valid_q & write_q & ~err_q & hreadyout_q;
  assign read_done = dp_valid_q & ~write_q & ~err_q & hreadyout_q;

  assign lane_mask = size_to_mask(size_q, off_q);
  assign wr_strb   = HWSTRB & STRB_W'(lane_mask);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < STRB_W; i++) bit_mask[8*i +: 8] = {8{wr_strb[i]}};
  end

  assign word_view = fwd_valid_q ? fwd_data_q : arr_rdata;
  assign merged    = (word_view & ~bit_mask) | (HWDATA & bit_mask);

  ahb_sram_subordinate_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (HCLK),
    .we    (commit),
    .waddr (idx_q),
    .wdata (HWDATA),
    .wstrb (wr_strb),
    .re    (accept),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      dp_valid_q  <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
    end else begin
      if (accept) begin
        idx_q   <= rd_idx;
        off_q   <= 3'(HADDR[LANE_BITS-1:0]);
        size_q  <= HSIZE;
        write_q <= HWRITE;
        err_q   <= req_err;
      end
      case (state_q)
        StIdle, StErr2: begin
          dp_valid_q <= accept;
          if (accept && req_err) begin
            state_q     <= StErr1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else if (accept && (WAIT_STATES != 0)) begin
            state_q     <= StWait;
            cnt_q       <= 3'(WAIT_STATES);
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        StWait: begin
          if (cnt_q <= 3'd1) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A read launched while a write to the same word commits sees the merged word.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else if (accept) begin
      fwd_valid_q <= commit && (rd_idx == idx_q);
      fwd_data_q  <= merged;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = read_done ? word_view : '0;
  assign HEXOKAY   = 1'b0;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: one subordinate with no wait states (d=0) and one with three (d=3).
module tb_ahb_sram_subordinate;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  hsel = '0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = '0;
  logic [3:0]  HWSTRB = '0;

  logic        ro0, rs0, ex0, ro3, rs3, ex3;
  logic [31:0] rd0, rd3;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_subordinate #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (1024), .WAIT_STATES (0)
  ) dut0 (
    .HCLK (HCLK), .HRESET (HRESET), .HSEL (hsel[0]), .HADDR (HADDR), .HTRANS (HTRANS),
    .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (3'b000), .HWDATA (HWDATA), .HWSTRB (HWSTRB),
    .HREADY (ro0), .HREADYOUT (ro0), .HRESP (rs0), .HRDATA (rd0), .HEXOKAY (ex0)
  );

  ahb_sram_subordinate #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (1024), .WAIT_STATES (3)
  ) dut3 (
    .HCLK (HCLK), .HRESET (HRESET), .HSEL (hsel[1]), .HADDR (HADDR), .HTRANS (HTRANS),
    .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (3'b000), .HWDATA (HWDATA), .HWSTRB (HWSTRB),
    .HREADY (ro3), .HREADYOUT (ro3), .HRESP (rs3), .HRDATA (rd3), .HEXOKAY (ex3)
  );

  function automatic logic rdy(input int d);
    return (d == 0) ? ro0 : ro3;
  endfunction

  function automatic logic rsp(input int d);
    return (d == 0) ? rs0 : rs3;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? rd0 : rd3;
  endfunction

  // Single non-pipelined transfer; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] strb, output int cycles,
                      output logic rdy_first, output logic resp_first, output logic resp_last,
                      output logic [31:0] rdata_last);
    hsel = (d == 0) ? 2'b01 : 2'b10;
    HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    hsel = '0; HTRANS = 2'b00; HWDATA = wdata; HWSTRB = strb;
    cycles = 0; rdy_first = 1'b0; resp_first = 1'b0;
    do begin
      @(negedge HCLK);
      cycles++;
      if (cycles == 1) begin rdy_first = rdy(d); resp_first = rsp(d); end
    end while (!rdy(d) && cycles < 20);
    resp_last = rsp(d); rdata_last = rdat(d);
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ro0 !== 1'b1 || ro3 !== 1'b1) begin errors++;
      $display("FAIL reset_hreadyout got %b/%b want 1/1", ro0, ro3); end
    checks++; if (rs0 !== 1'b0 || rs3 !== 1'b0) begin errors++;
      $display("FAIL reset_hresp got %b/%b want 0/0", rs0, rs3); end
    checks++; if (rd0 !== 32'h0 || rd3 !== 32'h0) begin errors++;
      $display("FAIL reset_hrdata got %h/%h want 0/0", rd0, rd3); end
    checks++; if (ex0 !== 1'b0 || ex3 !== 1'b0) begin errors++;
      $display("FAIL reset_hexokay got %b/%b want 0/0", ex0, ex3); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    hsel = 2'b01; HADDR = 32'h10; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HWDATA = 32'hDEADBEEF; HWSTRB = 4'hF; HWRITE = 1'b0;
    @(negedge HCLK);
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin errors++;
      $display("FAIL b2b_write_phase got rdy=%b resp=%b want 1/0", ro0, rs0); end
    @(posedge HCLK); #1;
    hsel = '0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin errors++;
      $display("FAIL b2b_read_phase got rdy=%b resp=%b want 1/0", ro0, rs0); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL b2b_read_data got %h want deadbeef", rd0); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_wait_states();
    int n; logic rf, pf, pl; logic [31:0] dl;
    xfer(3, 32'h20, 1'b1, 3'd2, 32'h12345678, 4'hF, n, rf, pf, pl, dl);
    checks++; if (n != 4 || pl !== 1'b0) begin errors++;
      $display("FAIL ws_write_len got cycles=%0d resp=%b want 4/0", n, pl); end
    xfer(3, 32'h24, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF, n, rf, pf, pl, dl);
    hsel = 2'b10; HADDR = 32'h20; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HADDR = 32'h24;
    n = 0;
    repeat (3) begin @(negedge HCLK); if (!ro3) n++; end
    checks++; if (n != 3) begin errors++;
      $display("FAIL ws_low_cycles got %0d want 3", n); end
    @(negedge HCLK);
    checks++; if (ro3 !== 1'b1 || rs3 !== 1'b0 || rd3 !== 32'h12345678) begin errors++;
      $display("FAIL ws_read_done got rdy=%b resp=%b data=%h want 1/0/12345678", ro3, rs3, rd3);
    end
    @(posedge HCLK); #1;
    hsel = '0; HTRANS = 2'b00;
    n = 0;
    do begin @(negedge HCLK); n++; end while (!ro3 && n < 20);
    checks++; if (n != 4 || rd3 !== 32'hCAFEF00D) begin errors++;
      $display("FAIL ws_pipelined_next got cycles=%0d data=%h want 4/cafef00d", n, rd3); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_byte_lanes();
    int n; logic rf, pf, pl; logic [31:0] dl;
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, 4'hF, n, rf, pf, pl, dl);
    checks++; if (n != 1 || pl !== 1'b0) begin errors++;
      $display("FAIL lane_word_write got cycles=%0d resp=%b want 1/0", n, pl); end
    xfer(0, 32'h13, 1'b1, 3'd0, 32'hAA000000, 4'hF, n, rf, pf, pl, dl);
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (dl !== 32'hAA223344) begin errors++;
      $display("FAIL lane_byte3 got %h want aa223344", dl); end
    xfer(0, 32'h14, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, n, rf, pf, pl, dl);
    xfer(0, 32'h14, 1'b1, 3'd2, 32'h00000000, 4'h2, n, rf, pf, pl, dl);
    xfer(0, 32'h14, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (dl !== 32'hFFFF00FF) begin errors++;
      $display("FAIL lane_strobe got %h want ffff00ff", dl); end
    xfer(0, 32'h16, 1'b1, 3'd1, 32'hBEEF1234, 4'hF, n, rf, pf, pl, dl);
    xfer(0, 32'h14, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (dl !== 32'hBEEF00FF) begin errors++;
      $display("FAIL lane_half_upper got %h want beef00ff", dl); end
  endtask

  task automatic test_errors();
    int n; logic rf, pf, pl; logic [31:0] dl;
    xfer(0, 32'h0, 1'b1, 3'd2, 32'h0BADF00D, 4'hF, n, rf, pf, pl, dl);
    xfer(0, 32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, n, rf, pf, pl, dl);
    checks++; if (rf !== 1'b0 || pf !== 1'b1) begin errors++;
      $display("FAIL err_range_err1 got rdy=%b resp=%b want 0/1", rf, pf); end
    checks++; if (n != 2 || pl !== 1'b1) begin errors++;
      $display("FAIL err_range_err2 got cycles=%0d resp=%b want 2/1", n, pl); end
    xfer(0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, n, rf, pf, pl, dl);
    checks++; if (n != 2 || pl !== 1'b1) begin errors++;
      $display("FAIL err_misalign got cycles=%0d resp=%b want 2/1", n, pl); end
    xfer(0, 32'h8, 1'b0, 3'd3, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (n != 2 || pl !== 1'b1 || dl !== 32'h0) begin errors++;
      $display("FAIL err_oversize got cycles=%0d resp=%b data=%h want 2/1/0", n, pl, dl); end
    xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (dl !== 32'h0BADF00D || pl !== 1'b0) begin errors++;
      $display("FAIL err_mem_unchanged got %h resp=%b want 0badf00d/0", dl, pl); end
    xfer(0, 32'hFFC, 1'b1, 3'd2, 32'h5A5A0FF0, 4'hF, n, rf, pf, pl, dl);
    xfer(0, 32'hFFC, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (dl !== 32'h5A5A0FF0 || pl !== 1'b0) begin errors++;
      $display("FAIL err_last_word got %h resp=%b want 5a5a0ff0/0", dl, pl); end
    xfer(3, 32'h1000, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (n != 2 || pf !== 1'b1 || pl !== 1'b1) begin errors++;
      $display("FAIL err_with_waits got cycles=%0d resp=%b/%b want 2/1/1", n, pf, pl); end
  endtask

  task automatic test_reset_mid_wait();
    int n; logic rf, pf, pl; logic [31:0] dl;
    xfer(3, 32'h30, 1'b1, 3'd2, 32'h01020304, 4'hF, n, rf, pf, pl, dl);
    hsel = 2'b10; HADDR = 32'h30; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    hsel = '0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF; HWSTRB = 4'hF;
    @(negedge HCLK);
    checks++; if (ro3 !== 1'b0) begin errors++;
      $display("FAIL rst_in_wait got rdy=%b want 0", ro3); end
    @(posedge HCLK); #2;
    HRESET = 1'b1;
    #1;
    checks++; if (ro3 !== 1'b1 || rs3 !== 1'b0 || rd3 !== 32'h0) begin errors++;
      $display("FAIL rst_async got rdy=%b resp=%b data=%h want 1/0/0", ro3, rs3, rd3); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    xfer(3, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0, n, rf, pf, pl, dl);
    checks++; if (n != 4 || pl !== 1'b0 || dl !== 32'h01020304) begin errors++;
      $display("FAIL rst_after got cycles=%0d resp=%b data=%h want 4/0/01020304", n, pl, dl); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
